// File: rtl/sr_cpu_pkg.sv
// ============================================================================
// Module : sr_cpu_pkg
// Brief  : Shared encodings, FSM state type and width limits for sr_cpu_param.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_cpu_pkg;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam int DW_MIN = 16;
  localparam int DW_MAX = 64;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  function automatic logic is_halt(input logic [2:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_cpu_regfile.sv
// ============================================================================
// Module : sr_cpu_regfile
// Brief  : NREG x DW register file, one write port, two combinational reads.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cpu_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr_a,
  input  logic [2:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/sr_cpu_param.sv
// ============================================================================
// Module : sr_cpu_param
// Brief  : Parametrised multicycle core for the simple RISC machine.
//          Optional HALT instruction enabled by macro SR_CPU_HALT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cpu_param
  import sr_cpu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic [DW-1:0] out,
  output logic          N,
  output logic          V,
  output logic          Z,
  output logic          w
);

  if (DW < DW_MIN || DW > DW_MAX) begin : g_dw_check
    $error("sr_cpu_param: DW out of range");
  end
  if (NREG != 8) begin : g_nreg_check
    $error("sr_cpu_param: NREG must be 8");
  end

  state_t        r_state;
  logic [15:0]   r_ir;
  logic [15:0]   r_xir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic          r_n;
  logic          r_v;
  logic          r_z;
  logic          r_w;

  // Execution uses a snapshot taken at start so a same-edge load only updates IR.
  logic [2:0]    w_opc;
  logic [1:0]    w_op;
  logic [2:0]    w_rn;
  logic [2:0]    w_rd;
  logic [1:0]    w_sh;
  logic [2:0]    w_rm;
  logic [7:0]    w_imm;
  assign w_opc = r_xir[15:13];
  assign w_op  = r_xir[12:11];
  assign w_rn  = r_xir[10:8];
  assign w_rd  = r_xir[7:5];
  assign w_sh  = r_xir[4:3];
  assign w_rm  = r_xir[2:0];
  assign w_imm = r_xir[7:0];

  logic          w_we;
  logic [2:0]    w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata_a;
  logic [DW-1:0] w_rdata_b;

  assign w_we    = (r_state == S_WRITE_REG) || (r_state == S_WRITE_IMM);
  assign w_waddr = (r_state == S_WRITE_IMM) ? w_rn : w_rd;
  assign w_wdata = (r_state == S_WRITE_IMM) ? {{(DW-8){w_imm[7]}}, w_imm} : r_c;

  sr_cpu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (w_we),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
    .raddr_a (w_rn),
    .raddr_b (w_rm),
    .rdata_a (w_rdata_a),
    .rdata_b (w_rdata_b)
  );

  logic [DW-1:0] w_bsh;
  always_comb begin
    w_bsh = r_b;
    case (w_sh)
      SH_LSL:  w_bsh = {r_b[DW-2:0], 1'b0};
      SH_LSR:  w_bsh = {1'b0, r_b[DW-1:1]};
      SH_ASR:  w_bsh = {r_b[DW-1], r_b[DW-1:1]};
      default: w_bsh = r_b;
    endcase
  end

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_res;
  logic          w_ovf;
  assign w_sum  = r_a + w_bsh;
  assign w_diff = r_a - w_bsh;

  always_comb begin
    w_res = w_bsh;
    w_ovf = 1'b0;
    if (w_opc == OPC_ALU) begin
      case (w_op)
        OP_ADD: begin
          w_res = w_sum;
          w_ovf = (r_a[DW-1] == w_bsh[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);
        end
        OP_CMP: begin
          w_res = w_diff;
          w_ovf = (r_a[DW-1] != w_bsh[DW-1]) && (w_diff[DW-1] != r_a[DW-1]);
        end
        OP_AND:  w_res = r_a & w_bsh;
        default: w_res = ~w_bsh;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_xir   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_w     <= 1'b1;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (load) r_ir <= in;
          if (s) begin
            r_xir   <= r_ir;
            r_state <= S_DECODE;
            r_w     <= 1'b0;
          end
        end
        S_DECODE: begin
          if (w_opc == OPC_MOV && w_op == OP_MOV_IMM) begin
            r_state <= S_WRITE_IMM;
          end else if (w_opc == OPC_MOV && w_op == OP_MOV_REG) begin
            r_state <= S_GET_B;
          end else if (w_opc == OPC_ALU) begin
            r_state <= (w_op == OP_MVN) ? S_GET_B : S_GET_A;
`ifdef SR_CPU_HALT_EN
          end else if (is_halt(w_opc)) begin
            r_state <= S_HALT;
`endif
          end else begin
            r_state <= S_WAIT;
            r_w     <= 1'b1;
          end
        end
        S_GET_A: begin
          r_a     <= w_rdata_a;
          r_state <= S_GET_B;
        end
        S_GET_B: begin
          r_b     <= w_rdata_b;
          r_state <= S_ALU;
        end
        S_ALU: begin
          r_c <= w_res;
          if (w_opc == OPC_ALU) begin
            r_z <= (w_res == '0);
            r_n <= w_res[DW-1];
            r_v <= w_ovf;
          end
          if (w_opc == OPC_ALU && w_op == OP_CMP) begin
            r_state <= S_WAIT;
            r_w     <= 1'b1;
          end else begin
            r_state <= S_WRITE_REG;
          end
        end
`ifdef SR_CPU_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: begin
          r_state <= S_WAIT;
          r_w     <= 1'b1;
        end
      endcase
    end
  end

  assign out = r_c;
  assign N   = r_n;
  assign V   = r_v;
  assign Z   = r_z;
  assign w   = r_w;

endmodule

`default_nettype wire
